// File: rtl/sd_spi_pkg.sv
// Shared constants and FSM encoding for the SPI SD card controller datapath.
// Keeps the fill pattern, fill counter width and fill FSM states in one place.
package sd_spi_pkg;

    localparam logic [7:0] FILL_BYTE_DEF = 8'hFF;
    localparam int         CNT_W_DEF     = 16;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } fill_state_e;

endpackage

// File: rtl/tx_cpu_buf.sv
// CPU-side TX staging buffer: two-byte stage (u then l) drained MSB first into the TX FIFO, zero latency.
// fifo_full stalls pushes without loss; CPU writes are refused via can_byte/can_word, and a hardware fill mode pushes FILL_BYTE.
module tx_cpu_buf
    import sd_spi_pkg::*;
#(
    parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEF,
    parameter int         CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_byte,
    input  logic             wr_word,
    input  logic [15:0]      wr_data,
    input  logic             fill_start,
    input  logic [CNT_W-1:0] fill_count,
    input  logic             fifo_full,
    output logic             fifo_wr,
    output logic [7:0]       fifo_data,
    output logic             can_byte,
    output logic             can_word,
    output logic             idle,
    output logic             filling
);

    logic [7:0]       r_u;
    logic [7:0]       r_l;
    logic             r_u_full;
    logic             r_l_full;
    fill_state_e      r_state;
    logic [CNT_W-1:0] r_rem;

    logic [7:0]       w_u_nxt;
    logic [7:0]       w_l_nxt;
    logic             w_u_full_nxt;
    logic             w_l_full_nxt;
    fill_state_e      w_state_nxt;
    logic [CNT_W-1:0] w_rem_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_u      <= '0;
            r_l      <= '0;
            r_u_full <= 1'b0;
            r_l_full <= 1'b0;
            r_state  <= S_IDLE;
            r_rem    <= '0;
        end else begin
            r_u      <= w_u_nxt;
            r_l      <= w_l_nxt;
            r_u_full <= w_u_full_nxt;
            r_l_full <= w_l_full_nxt;
            r_state  <= w_state_nxt;
            r_rem    <= w_rem_nxt;
        end
    end

    always_comb begin
        can_byte     = (r_state == S_IDLE) && !r_l_full;
        can_word     = (r_state == S_IDLE) && !r_u_full;
        idle         = (r_state == S_IDLE) && !r_u_full;
        filling      = (r_state == S_FILL);
        fifo_wr      = 1'b0;
        fifo_data    = r_u;
        w_u_nxt      = r_u;
        w_l_nxt      = r_l;
        w_u_full_nxt = r_u_full;
        w_l_full_nxt = r_l_full;
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;

        case (r_state)
            S_IDLE: begin
                fifo_wr = r_u_full && !fifo_full;
                if (fifo_wr) begin
                    w_u_nxt      = r_l;
                    w_u_full_nxt = r_l_full;
                    w_l_full_nxt = 1'b0;
                end
                // Writes land in the first slot left free after this cycle's drain.
                if (wr_byte && can_byte) begin
                    if (!w_u_full_nxt) begin
                        w_u_nxt      = wr_data[7:0];
                        w_u_full_nxt = 1'b1;
                    end else begin
                        w_l_nxt      = wr_data[7:0];
                        w_l_full_nxt = 1'b1;
                    end
                end else if (wr_word && can_word) begin
                    w_u_nxt      = wr_data[15:8];
                    w_l_nxt      = wr_data[7:0];
                    w_u_full_nxt = 1'b1;
                    w_l_full_nxt = 1'b1;
                end
                if (fill_start && idle && (fill_count != '0)) begin
                    w_state_nxt = S_FILL;
                    w_rem_nxt   = fill_count;
                end
            end
            S_FILL: begin
                fifo_wr   = !fifo_full;
                fifo_data = FILL_BYTE;
                if (fifo_wr && (r_rem != '0)) begin
                    w_rem_nxt = r_rem - 1'b1;
                    if (r_rem == CNT_W'(1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/tx_cpu_buf.md
Name: tx_cpu_buf

Overview:
- CPU-side transmit staging buffer for the SPI SD card controller; mirror of the receive-side CPU buffer.
- Accepts byte or 16-bit word writes from the CPU register interface and pushes bytes, MSB first, into the byte-wide TX FIFO.
- Also provides a hardware fill mode that pushes N copies of a fixed byte (0xFF idle pattern), so the CPU can clock in SD read data without issuing writes.

Parameters:
- FILL_BYTE, 8'hFF, byte value pushed during fill mode.
- CNT_W, 16, width of the fill length counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- wr_byte  in  1  CPU writes one byte, taken from wr_data[7:0].
- wr_word  in  1  CPU writes one word, wr_data[15:8] sent first.
- wr_data  in  16  CPU write data.
- fill_start  in  1  start fill of fill_count bytes.
- fill_count  in  CNT_W  number of FILL_BYTE bytes to push.
- fifo_full  in  1  TX FIFO cannot accept a byte this cycle.
- fifo_wr  out  1  push fifo_data into the TX FIFO this cycle.
- fifo_data  out  8  byte to push.
- can_byte  out  1  a wr_byte this cycle is accepted.
- can_word  out  1  a wr_word this cycle is accepted.
- idle  out  1  staging empty and no fill in progress.
- filling  out  1  fill mode active.

Behaviour:
- Staging registers: u (next byte out) and l, with flags u_full and l_full.
  - Invariant: l_full implies u_full. The state u_full=0, l_full=1 never occurs.
- FSM states: S_IDLE and S_FILL. Fill counter rem is CNT_W bits wide.
- Reset (reset_n=0 at a clk edge):
  - u_full=0, l_full=0, state=S_IDLE, rem=0.
  - Resulting outputs: fifo_wr=0, can_byte=1, can_word=1, idle=1, filling=0.
  - Reset mid-fill or mid-drain drops all staged and pending bytes. No further fifo_wr occurs.
- Combinational outputs, all derived from registered state plus fifo_full:
  - can_byte = (state==S_IDLE) && !l_full
  - can_word = (state==S_IDLE) && !u_full
  - idle = (state==S_IDLE) && !u_full
  - filling = (state==S_FILL)
  - In S_IDLE: fifo_wr = u_full && !fifo_full, and fifo_data = u.
  - In S_FILL: fifo_wr = !fifo_full, and fifo_data = FILL_BYTE.
- Drain in S_IDLE, when fifo_wr=1:
  - u <= l, u_full <= l_full, l_full <= 0.
  - Zero latency: a byte written at edge N is visible on fifo_data in cycle N+1 and pushed that cycle if fifo_full=0.
- Writes, evaluated after any same-cycle drain:
  - wr_byte is accepted only if can_byte. It appends to the first free slot of the post-drain state.
  - wr_byte with u_full=1, l_full=0 and a drain in the same cycle: u <= data, l stays empty.
  - wr_word is accepted only if can_word: u <= wr_data[15:8], l <= wr_data[7:0], both flags set.
  - wr_byte and wr_word asserted together: wr_byte wins and wr_word is ignored.
  - A write with its can_* low is silently dropped, with no state change.
- Fill:
  - fill_start is accepted only when idle=1; otherwise it is ignored.
  - fill_count=0 on an accepted fill_start is a no-op: state stays S_IDLE.
  - Otherwise: state <= S_FILL, rem <= fill_count.
  - In S_FILL, each cycle with fifo_wr=1 does rem <= rem-1. When rem==1 and fifo_wr=1, state <= S_IDLE.
  - fill_count=65535 yields exactly 65535 pushes. No wrap is possible because rem never decrements at 0.
  - CPU writes during S_FILL are dropped, since can_* are 0.
- fifo_full held high stalls all pushes indefinitely with no byte loss or duplication.

Decomposition:
- Shared package sd_spi_pkg:
  - FILL_BYTE default.
  - CNT_W.
  - FSM state encoding: S_IDLE=1'b0, S_FILL=1'b1.
- No sub-module. The staging pair and the fill FSM are small enough for a single module.

Test Plan:
- Reset, then wr_word 16'hA55A with fifo_full=0 -> fifo_wr pulses on the next 2 cycles with 8'hA5 then 8'h5A. idle returns to 1 after the second push.
- fifo_full=1, then wr_byte 8'h11, then wr_byte 8'h22, then a third wr_byte -> can_byte=0 after the second write and the third byte is dropped. Release fifo_full -> FIFO receives exactly 11, 22.
- u_full=1, l_full=0, fifo_full=0, wr_byte 8'h33 in the same cycle as the drain -> the pushes are u's byte then 33, with no gap or duplicate.
- fill_start with fill_count=5, fifo_full toggling every other cycle -> exactly 5 pushes of 8'hFF. filling=1 throughout, then idle=1. A wr_word during the fill is dropped.
- fill_start with fill_count=0 -> no fifo_wr and filling stays 0. fill_start while u_full=1 -> ignored.
- Assert reset_n=0 during a fill with rem=3 -> next cycle fifo_wr=0, idle=1, filling=0, can_word=1.
